pktfifo_arbiter: RTL

Packet-aware round-robin arbiter that drains up to NIN first-word-fall-through synchronous FIFOs into one AXI-stream-style output. It sits between the per-port ingress FIFOs of the switch and the shared forwarding datapath. It holds a grant for the whole packet, so packets from different FIFOs never interleave on the output.

---
 rtl/pktfifo_pkg.sv | 17 +
 rtl/pktfifo_arbiter_rr_pick.sv | 36 +++
 rtl/pktfifo_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/pktfifo_pkg.sv
// rtl/pktfifo_pkg.sv - shared state type, defaults and FIFO word layout for the packet FIFO arbiter
package pktfifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam int DEF_NIN = 4;
  localparam int DEF_DW  = 64;

  // FIFO word is {last, payload}: the last-of-packet flag sits just above the payload
  function automatic int last_bit(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/pktfifo_arbiter_rr_pick.sv
// rtl/pktfifo_arbiter_rr_pick.sv - combinational round-robin picker
// Grants the first request at or after i_ptr, searching upward and wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic                 o_found
);

  localparam int PW = $clog2(N);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // One spare bit keeps ptr+i from overflowing before the modulo-N wrap
      w_sum = {1'b0, i_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      w_idx = w_sum[PW-1:0];
      if (!o_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pktfifo_arbiter.sv
// rtl/pktfifo_arbiter.sv - packet-aware round-robin arbiter draining NIN FWFT FIFOs into one stream
// Stall watchdog is compiled in with PKTFIFO_ARBITER_WATCHDOG_EN.
module pktfifo_arbiter
  import pktfifo_pkg::*;
#(
  parameter int NIN       = DEF_NIN,
  parameter int DW        = DEF_DW,
  parameter int LGTIMEOUT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NIN-1:0]        i_empty,
  input  logic [NIN*(DW+1)-1:0] i_fifo_data,
  output logic [NIN-1:0]        o_rd,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DW-1:0]         M_DATA,
  output logic                  M_LAST,
  output logic                  o_grant_valid,
  output logic [NIN-1:0]        o_grant,
  output logic                  o_abort
);

  localparam int PW = $clog2(NIN);
  localparam int WW = DW + 1;
  localparam int LB = last_bit(DW);

  state_t         r_state;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_gidx;
  logic [NIN-1:0] r_grant;

  logic [WW-1:0]  w_words [NIN];
  logic [WW-1:0]  w_head;
  logic [NIN-1:0] w_pick;
  logic           w_found;
  logic [PW-1:0]  w_pick_idx;
  logic [PW-1:0]  w_next_ptr;
  logic           w_busy, w_valid, w_accept, w_eop, w_abort;

  for (genvar k = 0; k < NIN; k++) begin : g_unpack
    assign w_words[k] = i_fifo_data[k*WW +: WW];
  end

  rr_pick #(.N(NIN)) u_pick (
    .i_req   (~i_empty),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_found (w_found)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NIN; k++) begin
      if (w_pick[k]) w_pick_idx = PW'(k);
    end
  end

  assign w_busy     = (r_state == PKT);
  assign w_head     = w_words[r_gidx];
  assign w_valid    = w_busy && !i_empty[r_gidx];
  assign w_accept   = w_valid && M_READY;
  assign w_eop      = w_accept && w_head[LB];
  assign w_next_ptr = (r_gidx == PW'(NIN-1)) ? '0 : r_gidx + 1'b1;

  assign M_VALID       = w_valid;
  assign M_DATA        = w_busy ? w_head[DW-1:0] : '0;
  assign M_LAST        = w_busy && w_head[LB];
  assign o_rd          = w_accept ? r_grant : '0;
  assign o_grant_valid = w_busy;
  assign o_grant       = r_grant;

`ifdef PKTFIFO_ARBITER_WATCHDOG_EN
  logic [LGTIMEOUT-1:0] r_wd;

  // Fires on the stall cycle that would bring the count to its all-ones limit
  assign w_abort = w_busy && i_empty[r_gidx] && (r_wd == {{(LGTIMEOUT-1){1'b1}}, 1'b0});

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_busy || w_accept || w_abort) begin
      r_wd <= '0;
    end else if (i_empty[r_gidx]) begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_abort = 1'b0 && (LGTIMEOUT > 0);
`endif

  assign o_abort = w_abort;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= PKT;
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
          end
        end
        PKT: begin
          if (w_eop || w_abort) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
